icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Sequencing controller for the direct-mapped I-cache: 64 lines, 16-byte lines of 4 words, 22-bit tag.
- Accepts CPU fetch requests and drives the tag array's lookup, update and flush ports and the data array's read and write ports.
- On a miss, runs a 4-beat line refill from the memory interface, then replays the lookup.
- Sits between the CPU fetch stage, icache_tag_array, the data array and the bus master.

Parameters:
ADDR_WIDTH, 32, fetch address width.
INDEX_WIDTH, 6, line index bits (64 lines).
OFFSET_WIDTH, 4, byte offset bits (16-byte line, 4 words). Tag width = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH = 22.
CNT_WIDTH, 16, hit and miss counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  fetch request
cpu_req_addr  in  32  fetch address; bits[1:0] ignored
cpu_req_ready  out  1  request accepted when valid&ready
cpu_resp_valid  out  1  one-cycle response pulse
cpu_resp_data  out  32  instruction word, valid with cpu_resp_valid
flush_req  in  1  invalidate-all request pulse
flush_busy  out  1  flush pending or executing
tag_lookup_index  out  6  to tag array
tag_lookup_tag  out  22  to tag array
tag_hit  in  1  combinational hit from tag array
tag_update_valid  out  1  tag write strobe
tag_update_index  out  6  tag write index
tag_update_tag  out  22  tag write value
tag_flush_all  out  1  tag array flush strobe
data_rd_index  out  6  data array read line
data_rd_word  out  2  data array read word
data_rd_data  in  32  combinational read data
data_wr_en  out  1  data array write strobe
data_wr_index  out  6  data array write line
data_wr_word  out  2  data array write word
data_wr_data  out  32  data array write data
mem_req_valid  out  1  line-fill request
mem_req_addr  out  32  line-aligned fill address
mem_req_ready  in  1  request handshake
mem_rdata_valid  in  1  fill beat valid
mem_rdata  in  32  fill beat data
hit_count  out  16  saturating hit counter
miss_count  out  16  saturating miss counter

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, REFILL, UPDATE, FLUSH.
- Reset (async, rst=1):
  - State goes to IDLE; latched address, beat counter and flush_pending clear to 0.
  - Every output is 0 except cpu_req_ready, which is 1 after reset release.
  - An in-flight refill is abandoned.
  - Tag contents are not touched; the tag array has its own reset.
- Lookup and data-read ports are driven continuously from the latched address: index=addr[9:4], tag=addr[31:10], word=addr[3:2].
- IDLE:
  - cpu_req_ready = !flush_req && !flush_pending.
  - Request accepted: latch the address, go to LOOKUP.
  - flush_req or flush_pending set: go to FLUSH. A flush wins over a simultaneous request.
- LOOKUP, tag_hit=1:
  - cpu_resp_valid=1 and cpu_resp_data=data_rd_data for one cycle.
  - hit_count increments, except on a replay after a refill.
  - Go to IDLE. Hit latency is one cycle after the accept edge.
- LOOKUP, tag_hit=0:
  - miss_count increments; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1 and mem_req_addr={tag,index,4'b0}, both held stable until mem_req_ready.
  - On the handshake edge, go to REFILL with beat counter=0.
- REFILL:
  - Each mem_rdata_valid beat: data_wr_en=1, data_wr_index=latched index, data_wr_word=counter, data_wr_data=mem_rdata, then counter increments.
  - On beat 3, go to UPDATE. Beats arrive in word order 0..3.
  - mem_rdata_valid is ignored in every other state.
- UPDATE:
  - tag_update_valid=1 for exactly one cycle with the latched index and tag.
  - Go to LOOKUP (replay). The replay always hits, so miss latency = handshake + 4 beats + 2 cycles.
- FLUSH:
  - tag_flush_all=1 for exactly one cycle; flush_pending clears; go to IDLE.
- flush_req outside IDLE: set flush_pending. The in-progress request completes (including its response) before the flush runs.
- flush_busy = flush_pending || state==FLUSH.
- Counters saturate at 16'hFFFF.
- Back-to-back requests: a new request is accepted in the IDLE cycle after a response; there is no overlap.

Test Plan:
- Cold miss: after reset, fetch 0x0000_1234 → one mem_req with addr 0x0000_1230; 4 beats 0xA0..0xA3 write index 0x23, words 0..3; tag_update of index 0x23, tag 0x4; response data 0xA1; miss_count=1, hit_count=0.
- Hit: then fetch 0x0000_1238 → cpu_resp_valid one cycle after accept, data 0xA2, no mem_req; hit_count=1.
- Conflict: fetch 0x0000_5230 (same index, tag 0x14) → miss and refill; a following fetch of 0x0000_1230 misses again; miss_count=3.
- Flush: flush_req while idle → tag_flush_all one cycle, cpu_req_ready=0 that cycle; a re-fetch of 0x0000_1238 misses.
- Flush during refill: flush_req in beat 1 → refill and response complete, then tag_flush_all pulses once; flush_busy high throughout.
- Reset mid-refill: assert rst after beat 2 → outputs 0 immediately, state IDLE; stray mem_rdata_valid afterwards causes no data_wr_en.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - CPU, tag array, data array and memory signals of the I-cache controller
interface icache_ctrl_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
);
  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_WIDTH = OFFSET_WIDTH - 2;

  logic                    cpu_req_valid;
  logic [ADDR_WIDTH-1:0]   cpu_req_addr;
  logic                    cpu_req_ready;
  logic                    cpu_resp_valid;
  logic [31:0]             cpu_resp_data;
  logic                    flush_req;
  logic                    flush_busy;
  logic [INDEX_WIDTH-1:0]  tag_lookup_index;
  logic [TAG_WIDTH-1:0]    tag_lookup_tag;
  logic                    tag_hit;
  logic                    tag_update_valid;
  logic [INDEX_WIDTH-1:0]  tag_update_index;
  logic [TAG_WIDTH-1:0]    tag_update_tag;
  logic                    tag_flush_all;
  logic [INDEX_WIDTH-1:0]  data_rd_index;
  logic [WORD_WIDTH-1:0]   data_rd_word;
  logic [31:0]             data_rd_data;
  logic                    data_wr_en;
  logic [INDEX_WIDTH-1:0]  data_wr_index;
  logic [WORD_WIDTH-1:0]   data_wr_word;
  logic [31:0]             data_wr_data;
  logic                    mem_req_valid;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic                    mem_req_ready;
  logic                    mem_rdata_valid;
  logic [31:0]             mem_rdata;
  logic [CNT_WIDTH-1:0]    hit_count;
  logic [CNT_WIDTH-1:0]    miss_count;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, flush_req, tag_hit, data_rd_data,
           mem_req_ready, mem_rdata_valid, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, flush_busy,
           tag_lookup_index, tag_lookup_tag, tag_update_valid, tag_update_index,
           tag_update_tag, tag_flush_all, data_rd_index, data_rd_word,
           data_wr_en, data_wr_index, data_wr_word, data_wr_data,
           mem_req_valid, mem_req_addr, hit_count, miss_count
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, flush_req, tag_hit, data_rd_data,
           mem_req_ready, mem_rdata_valid, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, flush_busy,
           tag_lookup_index, tag_lookup_tag, tag_update_valid, tag_update_index,
           tag_update_tag, tag_flush_all, data_rd_index, data_rd_word,
           data_wr_en, data_wr_index, data_wr_word, data_wr_data,
           mem_req_valid, mem_req_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped I-cache sequencer: lookup, 4-beat refill, replay, flush
module icache_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
);
  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
  localparam int LA_WIDTH   = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_UPDATE, S_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [LA_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0] beat_q, beat_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  replay_q, replay_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic [WORD_WIDTH-1:0]  word;
  logic                   resp_fire;
  logic                   wr_fire;

  // addr_q holds the word address; byte offset bits [1:0] are never stored
  assign idx  = addr_q[OFFSET_WIDTH+INDEX_WIDTH-3:OFFSET_WIDTH-2];
  assign tag  = addr_q[LA_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH-2];
  assign word = addr_q[WORD_WIDTH-1:0];

  assign resp_fire = (state_q == S_LOOKUP) && bus.tag_hit;
  assign wr_fire   = (state_q == S_REFILL) && bus.mem_rdata_valid;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    flush_pending_d = flush_pending_q;
    replay_d        = replay_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;

    if (bus.flush_req && state_q != S_IDLE) flush_pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.flush_req || flush_pending_q) begin
          state_d = S_FLUSH;
        end else if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_req_addr[ADDR_WIDTH-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        replay_d = 1'b0;
        if (bus.tag_hit) begin
          if (!replay_q && hit_cnt_q != {CNT_WIDTH{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end else begin
          if (miss_cnt_q != {CNT_WIDTH{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (bus.mem_req_ready) begin
          beat_d  = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_rdata_valid) begin
          beat_d = beat_q + WORD_WIDTH'(1);
          if (beat_q == {WORD_WIDTH{1'b1}}) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        replay_d = 1'b1;
        state_d  = S_LOOKUP;
      end
      S_FLUSH: begin
        // the flush executing now covers any request raised in this same cycle
        flush_pending_d = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
      replay_q        <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
      replay_q        <= replay_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  assign bus.cpu_req_ready    = (state_q == S_IDLE) && !bus.flush_req && !flush_pending_q;
  assign bus.cpu_resp_valid   = resp_fire;
  assign bus.cpu_resp_data    = resp_fire ? bus.data_rd_data : 32'd0;
  assign bus.flush_busy       = flush_pending_q || (state_q == S_FLUSH);

  assign bus.tag_lookup_index = idx;
  assign bus.tag_lookup_tag   = tag;
  assign bus.tag_update_valid = (state_q == S_UPDATE);
  assign bus.tag_update_index = idx;
  assign bus.tag_update_tag   = tag;
  assign bus.tag_flush_all    = (state_q == S_FLUSH);

  assign bus.data_rd_index    = idx;
  assign bus.data_rd_word     = word;
  assign bus.data_wr_en       = wr_fire;
  assign bus.data_wr_index    = idx;
  assign bus.data_wr_word     = beat_q;
  assign bus.data_wr_data     = wr_fire ? bus.mem_rdata : 32'd0;

  assign bus.mem_req_valid    = (state_q == S_MISS_REQ);
  assign bus.mem_req_addr     = {tag, idx, {OFFSET_WIDTH{1'b0}}};

  assign bus.hit_count        = hit_cnt_q;
  assign bus.miss_count       = miss_cnt_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed bench for icache_ctrl with behavioural tag/data arrays
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_ctrl_if ifc ();
  icache_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural tag array (own storage, untouched by controller reset)
  logic [21:0] tag_mem [64];
  logic        tag_v   [64];
  logic [31:0] data_mem [256];

  assign ifc.tag_hit      = tag_v[ifc.tag_lookup_index] && (tag_mem[ifc.tag_lookup_index] == ifc.tag_lookup_tag);
  assign ifc.data_rd_data = data_mem[{ifc.data_rd_index, ifc.data_rd_word}];

  always @(posedge clk) begin
    if (ifc.tag_flush_all) begin
      for (int i = 0; i < 64; i++) tag_v[i] <= 1'b0;
    end else if (ifc.tag_update_valid) begin
      tag_v[ifc.tag_update_index]   <= 1'b1;
      tag_mem[ifc.tag_update_index] <= ifc.tag_update_tag;
    end
    if (ifc.data_wr_en) data_mem[{ifc.data_wr_index, ifc.data_wr_word}] <= ifc.data_wr_data;
  end

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] fill;
    logic [31:0] data;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input bit miss, input logic [31:0] fill,
                       input logic [31:0] exp_data, input int exp_h, input int exp_m,
                       input int flush_beat, input int rst_beat);
    int  waitc, phase, beat, mreqs, tupds, busy_bad, cyc;
    bit  got, flushed, aborted;
    waitc = 0; phase = 0; beat = 0; mreqs = 0; tupds = 0; busy_bad = 0;
    got = 0; flushed = 0; aborted = 0;
    while (!ifc.cpu_req_ready && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    chk("req_ready", ifc.cpu_req_ready, 1);
    ifc.cpu_req_valid = 1'b1;
    ifc.cpu_req_addr  = addr;
    for (cyc = 1; cyc <= 40 && !got && !aborted; cyc++) begin
      @(negedge clk);
      if (flushed && !ifc.flush_busy) busy_bad++;
      ifc.cpu_req_valid   = 1'b0;
      ifc.flush_req       = 1'b0;
      ifc.mem_req_ready   = 1'b0;
      ifc.mem_rdata_valid = 1'b0;
      if (phase == 1) begin
        phase = 2; beat = 0;
      end else if (phase == 2) begin
        beat++;
        if (beat == 4) phase = 3;
      end
      if (phase == 2 && beat == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {ifc.mem_req_valid, ifc.data_wr_en, ifc.tag_update_valid,
                            ifc.tag_flush_all, ifc.cpu_resp_valid, ifc.flush_busy}, 0);
        chk("rst_counts", {ifc.hit_count, ifc.miss_count}, 0);
        aborted = 1;
      end else begin
        if (phase == 2) begin
          ifc.mem_rdata_valid = 1'b1;
          ifc.mem_rdata       = fill + beat;
          if (beat == flush_beat) begin
            ifc.flush_req = 1'b1;
            flushed = 1;
          end
        end
        #1;
        if (phase == 2)
          chk("refill_write", {ifc.data_wr_en, ifc.data_wr_index, ifc.data_wr_word, ifc.data_wr_data},
              {1'b1, addr[9:4], 2'(beat), fill + beat});
        if (ifc.cpu_resp_valid) begin
          got = 1;
          chk("resp_latency", cyc, miss ? 8 : 1);
          chk("resp_data", ifc.cpu_resp_data, exp_data);
        end
        if (ifc.tag_update_valid) begin
          tupds++;
          chk("tag_update", {ifc.tag_update_index, ifc.tag_update_tag}, {addr[9:4], addr[31:10]});
        end
        if (phase == 0 && ifc.mem_req_valid) begin
          mreqs++;
          chk("mem_req_addr", ifc.mem_req_addr, {addr[31:4], 4'h0});
          ifc.mem_req_ready = 1'b1;
          phase = 1;
        end
      end
    end
    if (!aborted) begin
      if (!got) chk("resp_timeout", 0, 1);
      chk("mem_req_count", mreqs, miss ? 1 : 0);
      chk("tag_update_count", tupds, miss ? 1 : 0);
      if (flushed) chk("flush_busy_held", busy_bad, 0);
      @(negedge clk); #1;
      chk("hit_count", ifc.hit_count, exp_h);
      chk("miss_count", ifc.miss_count, exp_m);
    end
  endtask

  initial begin
    int pulses;
    vecs[0] = '{32'h0000_1234, 1'b1, 32'hA0, 32'hA1, 0, 1};
    vecs[1] = '{32'h0000_1238, 1'b0, 32'h00, 32'hA2, 1, 1};
    vecs[2] = '{32'h0000_5230, 1'b1, 32'hB0, 32'hB0, 1, 2};
    vecs[3] = '{32'h0000_1230, 1'b1, 32'hA0, 32'hA0, 1, 3};
    vecs[4] = '{32'h0000_123C, 1'b0, 32'h00, 32'hA3, 2, 3};
    vecs[5] = '{32'h0000_0040, 1'b1, 32'hC0, 32'hC0, 2, 4};
    vecs[6] = '{32'h0000_5234, 1'b1, 32'hB0, 32'hB1, 2, 5};
    vecs[7] = '{32'h0000_0044, 1'b0, 32'h00, 32'hC1, 3, 5};

    for (int i = 0; i < 64; i++) begin tag_v[i] = 1'b0; tag_mem[i] = '0; end
    for (int i = 0; i < 256; i++) data_mem[i] = '0;
    rst = 1'b1;
    ifc.cpu_req_valid = 0; ifc.cpu_req_addr = 0; ifc.flush_req = 0;
    ifc.mem_req_ready = 0; ifc.mem_rdata_valid = 0; ifc.mem_rdata = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {ifc.mem_req_valid, ifc.data_wr_en, ifc.tag_update_valid,
                          ifc.tag_flush_all, ifc.cpu_resp_valid, ifc.flush_busy}, 0);
    chk("reset_counts", {ifc.hit_count, ifc.miss_count}, 0);
    rst = 1'b0;
    #1;
    chk("reset_ready", ifc.cpu_req_ready, 1);

    for (int i = 0; i < 8; i++)
      fetch(vecs[i].addr, vecs[i].miss, vecs[i].fill, vecs[i].data, vecs[i].hits, vecs[i].misses, -1, -1);

    // flush while idle
    @(negedge clk); #1;
    ifc.flush_req = 1'b1;
    #1;
    chk("flush_req_blocks_ready", ifc.cpu_req_ready, 0);
    @(negedge clk);
    ifc.flush_req = 1'b0;
    #1;
    chk("flush_pulse", {ifc.tag_flush_all, ifc.cpu_req_ready, ifc.flush_busy}, 3'b101);
    @(negedge clk); #1;
    chk("flush_done", {ifc.tag_flush_all, ifc.cpu_req_ready, ifc.flush_busy}, 3'b010);
    fetch(32'h0000_1238, 1'b1, 32'hA0, 32'hA2, 3, 6, -1, -1);

    // flush raised during refill beat 1
    fetch(32'h0000_0080, 1'b1, 32'hD0, 32'hD0, 3, 7, 1, -1);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (ifc.tag_flush_all) pulses++;
      @(negedge clk); #1;
    end
    chk("deferred_flush_pulses", pulses, 1);
    chk("deferred_flush_idle", {ifc.flush_busy, ifc.cpu_req_ready}, 2'b01);

    // reset after beat 2 of a refill
    fetch(32'h0000_0100, 1'b1, 32'hE0, 32'hE2, 0, 0, -1, 3);
    @(negedge clk);
    rst = 1'b0;
    ifc.mem_rdata_valid = 1'b1;
    ifc.mem_rdata = 32'hDEAD;
    #1;
    chk("stray_beat_no_write", ifc.data_wr_en, 0);
    chk("post_reset_ready", ifc.cpu_req_ready, 1);
    @(negedge clk);
    ifc.mem_rdata_valid = 1'b0;
    #1;
    fetch(32'h0000_1238, 1'b1, 32'hA0, 32'hA2, 0, 1, -1, -1);
    fetch(32'h0000_123C, 1'b0, 32'h00, 32'hA3, 1, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
